// File: rtl/fab_clk_monitor.sv
// fab_clk_monitor
// Measures FAB_CLK against the 32.768 kHz LPXIN_CLKOUT reference and raises a
// real fabric lock once LOCK_CNT consecutive reference periods fall inside
// [EXP_MIN, EXP_MAX] FAB_CLK cycles. The reference is sampled as plain data,
// so the whole block lives in the FAB_CLK domain.
//
// Ports:
//   FAB_CLK       block clock
//   M2F_RESET_N   synchronous active-low reset
//   LPXIN_CLKOUT  reference clock, asynchronous, sampled as data
//   ENABLE        measurement enable (level); low forces IDLE
//   CLR_ERR       one-cycle pulse clearing ERR_FAST/ERR_SLOW/ERR_CNT
//   FAB_LOCK      in-window for LOCK_CNT consecutive periods
//   PERIOD        last measured period in FAB_CLK cycles
//   PERIOD_VALID  one-cycle pulse when PERIOD updates
//   ERR_FAST      sticky: a period was shorter than EXP_MIN
//   ERR_SLOW      sticky: a period was longer than EXP_MAX or timed out
//   ERR_CNT       bad periods + timeouts, saturating at 255
module fab_clk_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_MIN  = 2990,
  parameter int EXP_MAX  = 3115,
  parameter int LOCK_CNT = 4
) (
  input  logic             FAB_CLK,
  input  logic             M2F_RESET_N,
  input  logic             LPXIN_CLKOUT,
  input  logic             ENABLE,
  input  logic             CLR_ERR,
  output logic             FAB_LOCK,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             ERR_FAST,
  output logic             ERR_SLOW,
  output logic [7:0]       ERR_CNT
);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(EXP_MAX);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, h;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       good, good_inc;
  logic             meas, good_hit, bad, tmo;
  logic             is_fast, is_slow;
  logic             new_fast, new_slow, new_err;

  assign rise = s2 & ~h;

  // good saturates at LOCK_CNT so LOCKED can keep counting good periods
  assign good_inc = (good >= LOCK_C) ? good : good + 4'd1;

  always_comb begin
    state_nxt = state;
    meas      = 1'b0;
    good_hit  = 1'b0;
    bad       = 1'b0;
    tmo       = 1'b0;
    is_fast   = (cnt < MIN_C);
    is_slow   = (cnt > MAX_C);
    case (state)
      IDLE: if (ENABLE) state_nxt = ARM;
      // first edge after arming only starts the counter
      ARM:  if (rise) state_nxt = MEASURE;
      MEASURE, LOCKED: begin
        if (rise) begin
          meas = 1'b1;
          if (is_fast || is_slow) begin
            bad       = 1'b1;
            state_nxt = MEASURE;
          end else begin
            good_hit = 1'b1;
            if (good_inc == LOCK_C) state_nxt = LOCKED;
          end
        end else if (cnt == MAX_C) begin
          // a period at exactly EXP_MAX closes on this cycle's rise; without
          // one the reference is already too slow, so stop waiting
          tmo       = 1'b1;
          state_nxt = ARM;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // disable overrides everything, including a coincident rise
    if (!ENABLE) begin
      state_nxt = IDLE;
      meas      = 1'b0;
      good_hit  = 1'b0;
      bad       = 1'b0;
      tmo       = 1'b0;
    end
  end

  assign new_fast = bad & is_fast;
  assign new_slow = (bad & is_slow) | tmo;
  assign new_err  = bad | tmo;

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      h            <= 1'b0;
      cnt          <= '0;
      good         <= '0;
      FAB_LOCK     <= 1'b0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      ERR_FAST     <= 1'b0;
      ERR_SLOW     <= 1'b0;
      ERR_CNT      <= '0;
    end else begin
      state        <= state_nxt;
      s1           <= LPXIN_CLKOUT;
      s2           <= s1;
      h            <= s2;
      FAB_LOCK     <= (state_nxt == LOCKED);
      PERIOD_VALID <= meas;
      if (meas) PERIOD <= cnt;

      if (!ENABLE || state == IDLE) cnt <= '0;
      else if (rise)                cnt <= CNT_W'(1);
      else if (cnt != '1)           cnt <= cnt + CNT_W'(1);

      if (!ENABLE || state == IDLE || bad || tmo) good <= '0;
      else if (good_hit)                          good <= good_inc;

      // a clear coinciding with a fresh error leaves just that error behind
      if (CLR_ERR) begin
        ERR_FAST <= new_fast;
        ERR_SLOW <= new_slow;
        ERR_CNT  <= new_err ? 8'd1 : 8'd0;
      end else begin
        if (new_fast) ERR_FAST <= 1'b1;
        if (new_slow) ERR_SLOW <= 1'b1;
        if (new_err && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fab_clk_monitor.sv
// Bench for fab_clk_monitor with EXP_MIN=90, EXP_MAX=110, LOCK_CNT=4.
// The reference is driven in step with FAB_CLK so measured periods are exact.
// Each reference rise that closes a measured period pushes its expected
// report; a monitor pops one entry per PERIOD_VALID pulse.
module tb_fab_clk_monitor;

  logic        FAB_CLK = 1'b0;
  logic        M2F_RESET_N = 1'b0;
  logic        LPXIN_CLKOUT = 1'b0;
  logic        ENABLE = 1'b1;
  logic        CLR_ERR = 1'b0;
  logic        FAB_LOCK;
  logic [15:0] PERIOD;
  logic        PERIOD_VALID;
  logic        ERR_FAST;
  logic        ERR_SLOW;
  logic [7:0]  ERR_CNT;

  fab_clk_monitor #(.CNT_W(16), .EXP_MIN(90), .EXP_MAX(110), .LOCK_CNT(4)) dut (
    .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N), .LPXIN_CLKOUT(LPXIN_CLKOUT),
    .ENABLE(ENABLE), .CLR_ERR(CLR_ERR), .FAB_LOCK(FAB_LOCK), .PERIOD(PERIOD),
    .PERIOD_VALID(PERIOD_VALID), .ERR_FAST(ERR_FAST), .ERR_SLOW(ERR_SLOW),
    .ERR_CNT(ERR_CNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic [15:0] period;
    logic        ef;
    logic        es;
    logic [7:0]  ec;
    logic        lk;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: one expected report per PERIOD_VALID pulse
  always @(negedge FAB_CLK) begin
    if (M2F_RESET_N && PERIOD_VALID) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: PERIOD=%0d with nothing expected", PERIOD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (PERIOD !== e.period || ERR_FAST !== e.ef || ERR_SLOW !== e.es ||
            ERR_CNT !== e.ec || FAB_LOCK !== e.lk) begin
          n_err++;
          $display("FAIL period_report: got P=%0d F=%0b S=%0b C=%0d L=%0b expected P=%0d F=%0b S=%0b C=%0d L=%0b",
                   PERIOD, ERR_FAST, ERR_SLOW, ERR_CNT, FAB_LOCK,
                   e.period, e.ef, e.es, e.ec, e.lk);
        end
      end
    end
  end

  // One reference period of n cycles starting with a rise. If meas, that rise
  // closes the previous period and its expected report is queued first.
  // clr pulses CLR_ERR in the cycle the DUT detects this rise.
  task automatic step(input int n, input bit meas, input bit ef, input bit es,
                      input int ec, input bit lk, input bit clr);
    exp_t e;
    if (meas) begin
      e.period = 16'(last_n);
      e.ef = ef; e.es = es; e.ec = 8'(ec); e.lk = lk;
      sbq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      LPXIN_CLKOUT = (i < n / 2);
      CLR_ERR = clr && (i == 2);
      @(posedge FAB_CLK); #1;
    end
    CLR_ERR = 1'b0;
    last_n = n;
  endtask

  initial begin
    exp_t e;
    // 1. reset with enable high and reference toggling
    for (int i = 0; i < 5; i++) begin
      @(posedge FAB_CLK); #1;
      LPXIN_CLKOUT = ~LPXIN_CLKOUT;
      @(negedge FAB_CLK);
      chk("reset_outputs", 32'({FAB_LOCK, PERIOD_VALID, ERR_FAST, ERR_SLOW, ERR_CNT, PERIOD}), 32'd0);
    end
    LPXIN_CLKOUT = 1'b0;
    @(posedge FAB_CLK); #1;
    M2F_RESET_N = 1'b1;
    repeat (3) @(posedge FAB_CLK); #1;

    // 2. lock acquisition at 100 cycles
    step(100, 0, 0, 0, 0, 0, 0);
    step(100, 1, 0, 0, 0, 0, 0);
    step(100, 1, 0, 0, 0, 0, 0);
    step(100, 1, 0, 0, 0, 0, 0);
    step(100, 1, 0, 0, 0, 1, 0);

    // 3. one fast period, then relock
    step(80,  1, 0, 0, 0, 1, 0);
    step(100, 1, 1, 0, 1, 0, 0);
    step(100, 1, 1, 0, 1, 0, 0);
    step(100, 1, 1, 0, 1, 0, 0);
    step(100, 1, 1, 0, 1, 0, 0);
    step(100, 1, 1, 0, 1, 1, 0);

    // 4. reference stall: last rise reports 100, then timeout
    e.period = 16'd100; e.ef = 1; e.es = 0; e.ec = 8'd1; e.lk = 1;
    sbq.push_back(e);
    LPXIN_CLKOUT = 1'b1;
    repeat (50) @(posedge FAB_CLK); #1;
    LPXIN_CLKOUT = 1'b0;
    repeat (62) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    chk("stall_slow_before", 32'(ERR_SLOW), 32'd0);
    chk("stall_lock_before", 32'(FAB_LOCK), 32'd1);
    @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    chk("stall_slow_after", 32'(ERR_SLOW), 32'd1);
    chk("stall_lock_after", 32'(FAB_LOCK), 32'd0);
    chk("stall_errcnt", 32'(ERR_CNT), 32'd2);
    repeat (20) @(posedge FAB_CLK); #1;
    step(100, 0, 0, 0, 0, 0, 0);
    step(100, 1, 1, 1, 2, 0, 0);
    step(100, 1, 1, 1, 2, 0, 0);
    step(100, 1, 1, 1, 2, 0, 0);
    step(100, 1, 1, 1, 2, 1, 0);

    // 5. window boundaries
    step(90,  1, 1, 1, 2, 1, 0);   // closes 100
    step(110, 1, 1, 1, 2, 1, 0);   // closes 90: good
    step(89,  1, 1, 1, 2, 1, 0);   // closes 110: good
    step(111, 1, 1, 0, 1, 0, 1);   // closes 89 with CLR_ERR: fast wins, count 1
    step(50,  0, 0, 0, 0, 0, 0);   // 111 timed out (count 2); this edge re-arms
    for (int k = 0; k < 300; k++)
      step(50, 1, 1, 1, (3 + k > 255) ? 255 : 3 + k, 0, 0);

    // 6. disable while locked
    step(100, 1, 1, 1, 255, 0, 0);
    step(100, 1, 1, 1, 255, 0, 0);
    step(100, 1, 1, 1, 255, 0, 0);
    step(100, 1, 1, 1, 255, 0, 0);
    step(100, 1, 1, 1, 255, 1, 0);
    e.period = 16'd100; e.ef = 1; e.es = 1; e.ec = 8'd255; e.lk = 1;
    sbq.push_back(e);
    for (int i = 0; i < 100; i++) begin
      LPXIN_CLKOUT = (i < 50);
      if (i == 40) ENABLE = 1'b0;
      @(negedge FAB_CLK);
      if (i == 40) chk("dis_lock_before", 32'(FAB_LOCK), 32'd1);
      if (i == 41) begin
        chk("dis_lock_after", 32'(FAB_LOCK), 32'd0);
        chk("dis_period_kept", 32'(PERIOD), 32'd100);
        chk("dis_errs_kept", 32'({ERR_FAST, ERR_SLOW, ERR_CNT}), 32'h3FF);
      end
      @(posedge FAB_CLK); #1;
    end
    step(100, 0, 0, 0, 0, 0, 0);
    step(100, 0, 0, 0, 0, 0, 0);
    chk("disabled_lock", 32'(FAB_LOCK), 32'd0);
    ENABLE = 1'b1;
    step(100, 0, 0, 0, 0, 0, 0);
    step(100, 1, 1, 1, 255, 0, 0);
    step(100, 1, 1, 1, 255, 0, 0);
    step(100, 1, 1, 1, 255, 0, 0);
    step(100, 1, 1, 1, 255, 1, 0);
    repeat (10) @(posedge FAB_CLK);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    chk("final_lock", 32'(FAB_LOCK), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

endmodule
